wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares one register-file write port between MEM_WB and a multi-cycle result FIFO.
// Optional starvation guard enabled by defining WB_ARB_STARVE_GUARD_EN.
package wb_arb_pkg;
   typedef logic [4:0] reg_idx_t;
endpackage

module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int MC_FIFO_DEPTH = 2,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_RegWrite,
   input  reg_idx_t    wb_rd,
   input  logic [31:0] wb_Rd,
   input  logic        mc_issue,
   input  reg_idx_t    mc_issue_rd,
   input  logic        mc_valid,
   input  reg_idx_t    mc_rd,
   input  logic [31:0] mc_Rd,
   output logic        mc_ready,
   input  reg_idx_t    id_rs1,
   input  reg_idx_t    id_rs2,
   output logic        hazard_stall,
   output logic        pipe_hold,
   output logic        rf_RegWrite,
   output reg_idx_t    rf_rd,
   output logic [31:0] rf_Rd,
   output logic [31:0] pend_vec
);

   localparam int AW = (MC_FIFO_DEPTH > 1) ? $clog2(MC_FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   reg_idx_t    fifo_rd_q   [MC_FIFO_DEPTH];
   reg_idx_t    fifo_rd_d   [MC_FIFO_DEPTH];
   logic [31:0] fifo_data_q [MC_FIFO_DEPTH];
   logic [31:0] fifo_data_d [MC_FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   pend_q, pend_d;

   logic        empty;
   logic        full;
   logic        push;
   logic        pop;
   logic        wb_win;
   reg_idx_t    head_rd;
   logic [31:0] head_data;

   always_comb begin
      empty     = (count_q == '0);
      full      = (count_q == CW'(MC_FIFO_DEPTH));
      head_rd   = fifo_rd_q[rd_ptr_q];
      head_data = fifo_data_q[rd_ptr_q];
      mc_ready  = !full;
      wb_win    = wb_RegWrite && (wb_rd != '0);
   end

`ifdef WB_ARB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] starve_cnt_q, starve_cnt_d;

   always_comb begin
      pipe_hold = !rst && !empty && (starve_cnt_q >= SW'(STARVE_LIMIT));
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (empty || pop) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q < SW'(STARVE_LIMIT)) begin
         starve_cnt_d = starve_cnt_q + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   logic unused_starve_limit;

   assign unused_starve_limit = (STARVE_LIMIT > 0);

   always_comb begin
      pipe_hold = 1'b0;
   end
`endif

   // A held MEM_WB request yields to the FIFO head; otherwise the pipeline goes first.
   always_comb begin
      pop         = 1'b0;
      rf_RegWrite = 1'b0;
      rf_rd       = '0;
      rf_Rd       = '0;
      if (!rst) begin
         if (pipe_hold && !empty) begin
            pop = 1'b1;
         end else if (wb_win) begin
            rf_RegWrite = 1'b1;
            rf_rd       = wb_rd;
            rf_Rd       = wb_Rd;
         end else if (!empty) begin
            pop = 1'b1;
         end
      end
      if (pop) begin
         rf_RegWrite = 1'b1;
         rf_rd       = head_rd;
         rf_Rd       = head_data;
      end
   end

   // Results for x0 are acknowledged but never stored.
   always_comb begin
      push = !rst && mc_valid && mc_ready && (mc_rd != '0);
   end

   always_comb begin
      fifo_rd_d   = fifo_rd_q;
      fifo_data_d = fifo_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      if (push) begin
         fifo_rd_d[wr_ptr_q]   = mc_rd;
         fifo_data_d[wr_ptr_q] = mc_Rd;
         wr_ptr_d              = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   // Set is applied after clear so a same-cycle reissue keeps the index pending.
   always_comb begin
      pend_d = pend_q;
      if (pop) begin
         pend_d[head_rd] = 1'b0;
      end
      if (!rst && mc_issue && (mc_issue_rd != '0)) begin
         pend_d[mc_issue_rd] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   always_comb begin
      hazard_stall = (pend_q[id_rs1] && (id_rs1 != '0)) ||
                     (pend_q[id_rs2] && (id_rs2 != '0));
      pend_vec     = pend_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         pend_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
      end
   end

   always_ff @(posedge clk) begin
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed plus random stimulus for wb_port_arbiter with a queue-based model of the result FIFO and scoreboard.
module tb_wb_port_arbiter;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_RegWrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_Rd;
   logic        mc_issue;
   logic [4:0]  mc_issue_rd;
   logic        mc_valid;
   logic [4:0]  mc_rd;
   logic [31:0] mc_Rd;
   logic        mc_ready;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic        hazard_stall;
   logic        pipe_hold;
   logic        rf_RegWrite;
   logic [4:0]  rf_rd;
   logic [31:0] rf_Rd;
   logic [31:0] pend_vec;

   wb_port_arbiter #(.MC_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_Rd(wb_Rd),
      .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
      .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_Rd(mc_Rd), .mc_ready(mc_ready),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .hazard_stall(hazard_stall),
      .pipe_hold(pipe_hold),
      .rf_RegWrite(rf_RegWrite), .rf_rd(rf_rd), .rf_Rd(rf_Rd),
      .pend_vec(pend_vec)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [4:0]  m_rd[$];
   logic [31:0] m_d[$];
   logic [31:0] m_pend = '0;
   int          m_starve = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      wb_RegWrite = 1'b0; wb_rd = '0; wb_Rd = '0;
      mc_issue = 1'b0; mc_issue_rd = '0;
      mc_valid = 1'b0; mc_rd = '0; mc_Rd = '0;
      id_rs1 = '0; id_rs2 = '0;
   endtask

   // Compare this cycle's combinational outputs against the model, then advance model and clock.
   task automatic step();
      logic        ewe, ehold, eready, ehaz, epop;
      logic [4:0]  erd;
      logic [31:0] ed;
      int          occ;
      #2;
      occ   = m_rd.size();
      ehold = 1'b0;
`ifdef WB_ARB_STARVE_GUARD_EN
      ehold = !rst && (occ > 0) && (m_starve >= LIMIT);
`endif
      ewe = 1'b0; erd = '0; ed = '0; epop = 1'b0;
      if (!rst) begin
         if (ehold) epop = 1'b1;
         else if (wb_RegWrite && wb_rd != 0) begin
            ewe = 1'b1; erd = wb_rd; ed = wb_Rd;
         end else if (occ > 0) epop = 1'b1;
      end
      if (epop) begin
         ewe = 1'b1; erd = m_rd[0]; ed = m_d[0];
      end
      eready = (occ < DEPTH);
      ehaz   = (m_pend[id_rs1] && id_rs1 != 0) || (m_pend[id_rs2] && id_rs2 != 0);
      chk("rf_RegWrite", 32'(rf_RegWrite), 32'(ewe));
      chk("rf_rd", 32'(rf_rd), 32'(erd));
      chk("rf_Rd", rf_Rd, ed);
      chk("pipe_hold", 32'(pipe_hold), 32'(ehold));
      if (!rst) begin
         chk("mc_ready", 32'(mc_ready), 32'(eready));
         chk("hazard_stall", 32'(hazard_stall), 32'(ehaz));
         chk("pend_vec", pend_vec, m_pend);
      end
      if (rst) begin
         m_rd.delete(); m_d.delete();
         m_pend = '0; m_starve = 0;
      end else begin
         if (epop) begin
            m_pend[erd] = 1'b0;
            void'(m_rd.pop_front());
            void'(m_d.pop_front());
         end
         if (mc_issue && mc_issue_rd != 0) m_pend[mc_issue_rd] = 1'b1;
         m_pend[0] = 1'b0;
         if (mc_valid && eready && mc_rd != 0) begin
            m_rd.push_back(mc_rd);
            m_d.push_back(mc_Rd);
         end
         m_starve = (occ == 0 || epop) ? 0 : m_starve + 1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      #1;
      step();
      step();
      rst = 1'b0;

      // Simultaneous pipeline and multi-cycle writes: pipeline first, FIFO next cycle.
      wb_RegWrite = 1'b1; wb_rd = 5'd5; wb_Rd = 32'h0000_AAAA;
      mc_valid = 1'b1; mc_rd = 5'd6; mc_Rd = 32'h0000_BBBB;
      step();
      idle();
      step();
      step();

      // RAW hazard on x7 until its result drains.
      mc_issue = 1'b1; mc_issue_rd = 5'd7;
      step();
      idle(); id_rs1 = 5'd7;
      step();
      step();
      mc_valid = 1'b1; mc_rd = 5'd7; mc_Rd = 32'h0000_0077;
      step();
      mc_valid = 1'b0;
      step();
      step();
      idle();

      // FIFO fills while the pipeline keeps the port busy.
      wb_RegWrite = 1'b1; wb_rd = 5'd1; wb_Rd = 32'h0000_1111;
      mc_valid = 1'b1; mc_rd = 5'd10; mc_Rd = 32'h0000_00A0;
      step();
      mc_rd = 5'd11; mc_Rd = 32'h0000_00B0;
      step();
      mc_rd = 5'd12; mc_Rd = 32'h0000_00C0;
      for (int i = 0; i < 6; i++) begin
         wb_Rd = 32'h1000 + i;
         step();
      end
      mc_valid = 1'b0; wb_RegWrite = 1'b0;
      for (int i = 0; i < 4; i++) step();
      idle();

      // Result addressed to x0 is swallowed.
      mc_valid = 1'b1; mc_rd = 5'd0; mc_Rd = 32'h0000_DEAD;
      step();
      idle();
      step();

      // Reset with queued entries and a pending index; issue during reset is ignored.
      mc_issue = 1'b1; mc_issue_rd = 5'd3;
      wb_RegWrite = 1'b1; wb_rd = 5'd2; wb_Rd = 32'h0000_2222;
      mc_valid = 1'b1; mc_rd = 5'd20; mc_Rd = 32'h0000_0020;
      step();
      mc_issue = 1'b0; mc_rd = 5'd21; mc_Rd = 32'h0000_0021;
      step();
      mc_valid = 1'b0;
      rst = 1'b1; mc_issue = 1'b1; mc_issue_rd = 5'd4;
      step();
      rst = 1'b0;
      idle();
      step();
      step();

      // Reissue of x9 in the same cycle its previous result is popped.
      mc_issue = 1'b1; mc_issue_rd = 5'd9;
      step();
      idle();
      mc_valid = 1'b1; mc_rd = 5'd9; mc_Rd = 32'h0000_0099;
      step();
      mc_valid = 1'b0; mc_issue = 1'b1; mc_issue_rd = 5'd9; id_rs2 = 5'd9;
      step();
      mc_issue = 1'b0;
      step();
      mc_valid = 1'b1; mc_rd = 5'd9; mc_Rd = 32'h0000_009A;
      step();
      mc_valid = 1'b0;
      step();
      step();
      idle();

      // Pipeline write to x0 does not block the FIFO.
      mc_valid = 1'b1; mc_rd = 5'd13; mc_Rd = 32'h0000_0013;
      step();
      mc_valid = 1'b0; wb_RegWrite = 1'b1; wb_rd = 5'd0; wb_Rd = 32'h0000_FFFF;
      step();
      idle();
      step();

      // Random traffic exercises pointer wrap and ordering.
      for (int i = 0; i < 60; i++) begin
         wb_RegWrite = ($urandom_range(0, 2) == 0);
         wb_rd       = 5'($urandom_range(0, 31));
         wb_Rd       = $urandom;
         mc_issue    = ($urandom_range(0, 3) == 0);
         mc_issue_rd = 5'($urandom_range(0, 31));
         mc_valid    = ($urandom_range(0, 1) == 0);
         mc_rd       = 5'($urandom_range(0, 31));
         mc_Rd       = $urandom;
         id_rs1      = 5'($urandom_range(0, 31));
         id_rs2      = 5'($urandom_range(0, 31));
         step();
      end
      idle();
      for (int i = 0; i < 4; i++) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
